// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    // Controller states: waiting, shifting bits, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width; never below one bit so the counter always exists.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Parallel load / result bundle of the bit-serial adder.
// With SERIAL_ADDER_SUB_EN defined the bundle also carries the sub request.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a_in, b_in, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a_in, b_in, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a_in, b_in, cin, input busy, done, sum, cout);
    modport slave  (input start, a_in, b_in, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single full-adder cell: the only arithmetic in the serial adder.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | ((a_i ^ b_i) & c_i);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a registered carry and
// shift registers, one bit pair per clock LSB first; result after WIDTH clocks.
// Defining SERIAL_ADDER_SUB_EN adds a sub request (A - B via inverted B, carry 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_adder_if.slave bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] load_b;
    logic             load_c;

    // Operand conditioning at load time: subtract is A + ~B + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign load_b = bus.sub ? ~bus.b_in : bus.b_in;
    assign load_c = bus.sub ? 1'b1 : bus.cin;
`else
    assign load_b = bus.b_in;
    assign load_c = bus.cin;
`endif

    fa_cell u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // Next-state and datapath update for the serial add controller.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        shift_d = shift_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a_in;
                    b_d     = load_b;
                    carry_d = load_c;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                shift_d = {fa_s, shift_q[WIDTH-1:1]};
                carry_d = fa_co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Publish the full result, including this edge's bit.
                    state_d = DONE;
                    sum_d   = {fa_s, shift_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, randomized
// operands against an arithmetic model, start-ignore, back-to-back and reset abort.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected architectural result held by the bench.
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain (WIDTH+1)-bit arithmetic.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic c,
                                             input logic s);
        logic [WIDTH:0] r;
        logic [WIDTH-1:0] nb;
        nb = ~b;
        if (s) r = {1'b0, a} + {1'b0, nb} + (WIDTH+1)'(1);
        else   r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
        return r;
    endfunction

    // One full operation; entered just after a clock edge. inject_at>0 pulses
    // start with foreign operands before that run edge (must be ignored).
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s, input int inject_at,
                         input string name);
        logic [WIDTH:0] exp;
        exp = model(a, b, c, s);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = c;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = s;
`endif
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a_in  = WIDTH'($urandom);
        bus.b_in  = WIDTH'($urandom);
        bus.cin   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'($urandom);
`endif
        tests_run++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s accept: busy=%b done=%b expected busy=1 done=0", name, bus.busy, bus.done);
        end
        for (int k = 1; k <= WIDTH; k++) begin
            if (k == inject_at) begin
                bus.start = 1'b1;
                bus.a_in  = 8'h80;
                bus.b_in  = 8'h80;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            tests_run++;
            if (k < WIDTH) begin
                if (bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                    bus.sum !== exp_sum || bus.cout !== exp_cout) begin
                    tests_failed++;
                    $display("FAIL %s run bit %0d: busy=%b done=%b sum=%h cout=%b expected busy=1 done=0 sum=%h cout=%b",
                             name, k, bus.busy, bus.done, bus.sum, bus.cout, exp_sum, exp_cout);
                end
            end else begin
                exp_sum  = exp[WIDTH-1:0];
                exp_cout = exp[WIDTH];
                if (bus.busy !== 1'b0 || bus.done !== 1'b1 ||
                    bus.sum !== exp_sum || bus.cout !== exp_cout) begin
                    tests_failed++;
                    $display("FAIL %s result: busy=%b done=%b sum=%h cout=%b expected busy=0 done=1 sum=%h cout=%b",
                             name, bus.busy, bus.done, bus.sum, bus.cout, exp_sum, exp_cout);
                end
            end
        end
    endtask

    // Idle cycles: no activity, result held.
    task automatic idle_hold(input int n, input string name);
        bus.start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
                bus.sum !== exp_sum || bus.cout !== exp_cout) begin
                tests_failed++;
                $display("FAIL %s idle %0d: busy=%b done=%b sum=%h cout=%b expected busy=0 done=0 sum=%h cout=%b",
                         name, k, bus.busy, bus.done, bus.sum, bus.cout, exp_sum, exp_cout);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;      // reset must win over start
        bus.a_in  = 8'hAA;
        bus.b_in  = 8'h55;
        bus.cin   = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset ctrl: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        tests_run++;
        if (bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset result: sum=%h cout=%b expected 00 0", bus.sum, bus.cout);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        idle_hold(2, "post_reset");
    endtask

    task automatic test_directed();
        do_op(8'h25, 8'h17, 1'b0, 1'b0, 0, "add_25_17");
        idle_hold(1, "add_25_17");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, "add_ff_01");
        idle_hold(3, "add_ff_01_hold");
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "add_ff_ff_c1");
        idle_hold(1, "add_ff_ff_c1");
    endtask

    task automatic test_start_ignored();
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 3, "start_ignored");
        idle_hold(1, "start_ignored");
    endtask

    task automatic test_back_to_back();
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 0, "b2b_first");
        do_op(8'hC3, 8'h7E, 1'b1, 1'b0, 0, "b2b_second");
        do_op(8'h00, 8'h00, 1'b0, 1'b0, 0, "b2b_third");
        idle_hold(1, "b2b");
    endtask

    task automatic test_reset_mid_run();
        bus.start = 1'b1;
        bus.a_in  = 8'h55;
        bus.b_in  = 8'hAA;
        bus.cin   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        idle_hold(WIDTH + 2, "reset_mid_run_no_done");
        do_op(8'h55, 8'hAA, 1'b1, 1'b0, 0, "after_abort");
        idle_hold(1, "after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0, "random");
            if ($urandom_range(0, 1) == 1) idle_hold(1, "random");
        end
        idle_hold(1, "random_end");
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        do_op(8'h10, 8'h20, 1'b0, 1'b1, 0, "sub_10_20");
        do_op(8'h20, 8'h10, 1'b1, 1'b1, 0, "sub_20_10");
        do_op(8'h37, 8'h37, 1'b0, 1'b1, 0, "sub_equal");
        do_op(8'h37, 8'h01, 1'b1, 1'b0, 0, "add_after_sub");
        idle_hold(1, "sub");
    endtask
`endif

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        exp_sum   = '0;
        exp_cout  = 1'b0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
